// File: rtl/rgb_grayscaler_stream.sv
// ---------------------------------------------------------------------------
// rgb_grayscaler_stream
//
// Streaming RGB-to-luma converter with a 2-stage elastic pipeline.
// Stage 1 registers the three weighted products together with the raw
// pixel, the mode and the threshold. Stage 2 sums and normalises the products,
// clamps the luma, applies the per-pixel mode and registers the outputs.
// Both sides use valid/ready handshakes and support full backpressure.
//
// Parameters:
//   DataWidth   bits per colour channel
//   WeightWidth bits per weight; luma is normalised by >> WeightWidth
//   RWeight, GWeight, BWeight  compile-time luma weights
//   CntWidth    width of the output pixel counter
//
// Ports:
//   clk_i, rst_i         clock (rising edge), async active-high reset
//   valid_i / ready_o    input handshake
//   r_i, g_i, b_i        input pixel
//   mode_i               00 bypass, 01 gray, 10 inverted gray, 11 threshold
//   thresh_i             threshold used in mode 11
//   valid_o / ready_i    output handshake
//   r_o, g_o, b_o        registered output pixel
//   pix_cnt_o            completed output handshakes (wraps)
// ---------------------------------------------------------------------------
module rgb_grayscaler_stream #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned WeightWidth = 8,
  parameter int unsigned RWeight     = 77,
  parameter int unsigned GWeight     = 150,
  parameter int unsigned BWeight     = 28,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] r_i,
  input  logic [DataWidth-1:0] g_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [1:0]           mode_i,
  input  logic [DataWidth-1:0] thresh_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] r_o,
  output logic [DataWidth-1:0] g_o,
  output logic [DataWidth-1:0] b_o,
  output logic [CntWidth-1:0]  pix_cnt_o
);

  // Widths of the arithmetic path. The sum of three products needs two extra
  // bits; after the shift that leaves DataWidth+2 bits of unclamped luma.
  localparam int unsigned ProdWidth = DataWidth + WeightWidth;
  localparam int unsigned SumWidth  = ProdWidth + 2;
  localparam int unsigned YWidth    = SumWidth - WeightWidth;

  localparam logic [WeightWidth-1:0] RW     = WeightWidth'(RWeight);
  localparam logic [WeightWidth-1:0] GW     = WeightWidth'(GWeight);
  localparam logic [WeightWidth-1:0] BW     = WeightWidth'(BWeight);
  localparam logic [DataWidth-1:0]   PixMax = '1;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_GRAY   = 2'b01,
    MODE_INV    = 2'b10,
    MODE_THRESH = 2'b11
  } mode_e;

  // -------------------------------------------------------------------------
  // Handshake and stage enables
  // -------------------------------------------------------------------------
  logic w_en1;
  logic w_en2;
  logic w_in_hs;
  logic w_out_hs;

  logic r_v1;
  logic r_v2;

  // A stage may load when it is empty or when the stage after it is moving.
  // ready_o is therefore combinationally dependent on ready_i.
  assign w_en2    = !r_v2 || ready_i;
  assign w_en1    = !r_v1 || w_en2;
  assign ready_o  = w_en1;
  assign valid_o  = r_v2;
  assign w_in_hs  = valid_i && w_en1;
  assign w_out_hs = r_v2 && ready_i;

  // -------------------------------------------------------------------------
  // Stage 1: weighted products plus the side data that travels with the pixel
  // -------------------------------------------------------------------------
  logic [ProdWidth-1:0] w_r_prod;
  logic [ProdWidth-1:0] w_g_prod;
  logic [ProdWidth-1:0] w_b_prod;

  assign w_r_prod = ProdWidth'(r_i) * ProdWidth'(RW);
  assign w_g_prod = ProdWidth'(g_i) * ProdWidth'(GW);
  assign w_b_prod = ProdWidth'(b_i) * ProdWidth'(BW);

  logic [ProdWidth-1:0] r_s1_r_prod;
  logic [ProdWidth-1:0] r_s1_g_prod;
  logic [ProdWidth-1:0] r_s1_b_prod;
  logic [DataWidth-1:0] r_s1_r;
  logic [DataWidth-1:0] r_s1_g;
  logic [DataWidth-1:0] r_s1_b;
  mode_e                r_s1_mode;
  logic [DataWidth-1:0] r_s1_thresh;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of its inputs, independent of
  // the order in which the always_ff blocks are evaluated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1        <= 1'b0;
      r_s1_r_prod <= '0;
      r_s1_g_prod <= '0;
      r_s1_b_prod <= '0;
      r_s1_r      <= '0;
      r_s1_g      <= '0;
      r_s1_b      <= '0;
      r_s1_mode   <= MODE_BYPASS;
      r_s1_thresh <= '0;
    end else if (w_en1) begin
      // v1 follows valid_i: set on an input handshake, cleared when the
      // pixel moves on to stage 2 with nothing new arriving behind it.
      r_v1 <= valid_i;
      if (valid_i) begin
        r_s1_r_prod <= w_r_prod;
        r_s1_g_prod <= w_g_prod;
        r_s1_b_prod <= w_b_prod;
        r_s1_r      <= r_i;
        r_s1_g      <= g_i;
        r_s1_b      <= b_i;
        r_s1_mode   <= mode_e'(mode_i);
        r_s1_thresh <= thresh_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 combinational: sum, normalise, clamp, apply mode
  // -------------------------------------------------------------------------
  logic [SumWidth-1:0]  w_sum;
  logic [YWidth-1:0]    w_y_wide;
  logic [DataWidth-1:0] w_y;

  assign w_sum    = SumWidth'(r_s1_r_prod) + SumWidth'(r_s1_g_prod) + SumWidth'(r_s1_b_prod);
  // Truncating normalisation; no rounding.
  assign w_y_wide = YWidth'(w_sum >> WeightWidth);
  // Only reachable when the weights sum to more than 2^WeightWidth.
  assign w_y      = (w_y_wide > YWidth'(PixMax)) ? PixMax : w_y_wide[DataWidth-1:0];

  logic [DataWidth-1:0] w_r_res;
  logic [DataWidth-1:0] w_g_res;
  logic [DataWidth-1:0] w_b_res;

  // NOTE: every output of this block is assigned a default before the case so
  // no path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_r_res = r_s1_r;
    w_g_res = r_s1_g;
    w_b_res = r_s1_b;
    case (r_s1_mode)
      MODE_GRAY: begin
        w_r_res = w_y;
        w_g_res = w_y;
        w_b_res = w_y;
      end
      MODE_INV: begin
        w_r_res = PixMax - w_y;
        w_g_res = PixMax - w_y;
        w_b_res = PixMax - w_y;
      end
      MODE_THRESH: begin
        w_r_res = (w_y >= r_s1_thresh) ? PixMax : '0;
        w_g_res = (w_y >= r_s1_thresh) ? PixMax : '0;
        w_b_res = (w_y >= r_s1_thresh) ? PixMax : '0;
      end
      default: begin
        // Bypass: raw channels, already set above.
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 2 registers: output pixel and valid
  // -------------------------------------------------------------------------
  logic [DataWidth-1:0] r_r_out;
  logic [DataWidth-1:0] r_g_out;
  logic [DataWidth-1:0] r_b_out;

  // NOTE: the datapath registers are reset along with the valid flags so the
  // outputs read as zero during and right after reset rather than as X or as
  // leftovers from a discarded pixel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v2    <= 1'b0;
      r_r_out <= '0;
      r_g_out <= '0;
      r_b_out <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      // Outputs only change when a real pixel arrives; while stalled w_en2 is
      // low and they hold.
      if (r_v1) begin
        r_r_out <= w_r_res;
        r_g_out <= w_g_res;
        r_b_out <= w_b_res;
      end
    end
  end

  assign r_o = r_r_out;
  assign g_o = r_g_out;
  assign b_o = r_b_out;

  // -------------------------------------------------------------------------
  // Output pixel counter, wraps naturally at 2^CntWidth
  // -------------------------------------------------------------------------
  logic [CntWidth-1:0] r_pix_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pix_cnt <= '0;
    end else if (w_out_hs) begin
      r_pix_cnt <= r_pix_cnt + CntWidth'(1);
    end
  end

  assign pix_cnt_o = r_pix_cnt;

endmodule
